// File: rtl/pipeline_hazard_ctrl_if.sv
// Bundle of hazard-relevant pipeline-register fields and the controls driven
// back to the pipeline registers and the PC.
interface pipeline_hazard_ctrl_if #(
    parameter int REG_W = 5,
    parameter int CNT_W = 32
);
    logic [31:0]      ifid_instr;
    logic             idex_memread;
    logic [REG_W-1:0] idex_rd;
    logic             ex_branch_tkn;
    logic             exmem_memread;
    logic             exmem_memwrite;
    logic             dmem_ready;

    logic             pc_write;
    logic             ifid_write;
    logic             ifid_flush;
    logic             idex_write;
    logic             idex_flush;
    logic             exmem_write;
    logic             memwb_bubble;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;
    logic             mem_timeout;

    // Pipeline side: presents register fields, consumes controls
    modport master (
        output ifid_instr, idex_memread, idex_rd, ex_branch_tkn,
               exmem_memread, exmem_memwrite, dmem_ready,
        input  pc_write, ifid_write, ifid_flush, idex_write, idex_flush,
               exmem_write, memwb_bubble, stall_cnt, flush_cnt, mem_timeout
    );

    // Controller side
    modport slave (
        input  ifid_instr, idex_memread, idex_rd, ex_branch_tkn,
               exmem_memread, exmem_memwrite, dmem_ready,
        output pc_write, ifid_write, ifid_flush, idex_write, idex_flush,
               exmem_write, memwb_bubble, stall_cnt, flush_cnt, mem_timeout
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard controller for a 5-stage pipeline: load-use bubbles, taken-branch
// squash, variable-latency data-memory freeze, saturating perf counters and a
// sticky memory-timeout flag.
module pipeline_hazard_ctrl #(
    parameter int REG_W       = 5,
    parameter int CNT_W       = 32,
    parameter int MEM_TIMEOUT = 255
) (
    input  logic                   clk,
    input  logic                   reset,
    pipeline_hazard_ctrl_if.slave  bus
);
    localparam logic [0:0] RUN      = 1'b0;
    localparam logic [0:0] MEM_WAIT = 1'b1;

    localparam int               WAIT_W   = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MEM_TIMEOUT);
    localparam logic [WAIT_W-1:0] WAIT_ONE = WAIT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

    logic [0:0]        state_reg, state_next;
    logic [WAIT_W-1:0] wait_cnt_reg, wait_cnt_next;
    logic [CNT_W-1:0]  stall_cnt_reg, stall_cnt_next;
    logic [CNT_W-1:0]  flush_cnt_reg, flush_cnt_next;
    logic              mem_timeout_reg, mem_timeout_next;

    logic [REG_W-1:0]  rs1, rs2;
    logic              mem_access, freeze, load_use, branch;
    logic              pc_write, ifid_write, ifid_flush, idex_write;
    logic              idex_flush, exmem_write, memwb_bubble;

    // Source fields are compared regardless of opcode (conservative match)
    assign rs1        = REG_W'(bus.ifid_instr[19:15]);
    assign rs2        = REG_W'(bus.ifid_instr[24:20]);
    assign mem_access = bus.exmem_memread | bus.exmem_memwrite;
    assign freeze     = mem_access & ~bus.dmem_ready;
    assign branch     = bus.ex_branch_tkn & ~freeze;
    assign load_use   = bus.idex_memread & (bus.idex_rd != '0) &
                        ((bus.idex_rd == rs1) | (bus.idex_rd == rs2));

    // Mealy control outputs: reset > freeze > taken branch > load-use > normal
    always_comb begin
        pc_write     = 1'b1;
        ifid_write   = 1'b1;
        ifid_flush   = 1'b0;
        idex_write   = 1'b1;
        idex_flush   = 1'b0;
        exmem_write  = 1'b1;
        memwb_bubble = 1'b0;
        if (!reset) begin
            pc_write     = 1'b0;
            ifid_write   = 1'b0;
            ifid_flush   = 1'b1;
            idex_write   = 1'b0;
            idex_flush   = 1'b1;
            exmem_write  = 1'b0;
            memwb_bubble = 1'b1;
        end else if (freeze) begin
            // All stages hold; pending branch/load-use re-evaluate after release
            pc_write     = 1'b0;
            ifid_write   = 1'b0;
            idex_write   = 1'b0;
            exmem_write  = 1'b0;
            memwb_bubble = 1'b1;
        end else if (bus.ex_branch_tkn) begin
            // Squash the two younger instructions; a load-use consumer dies here too
            ifid_flush   = 1'b1;
            idex_flush   = 1'b1;
        end else if (load_use) begin
            // Hold PC and IF/ID for one cycle, inject a single bubble into ID/EX
            pc_write     = 1'b0;
            ifid_write   = 1'b0;
            idex_flush   = 1'b1;
        end
    end

    // Next-state: memory-wait tracking, timeout detection, saturating counters
    always_comb begin
        state_next       = state_reg;
        wait_cnt_next    = wait_cnt_reg;
        mem_timeout_next = mem_timeout_reg;
        stall_cnt_next   = stall_cnt_reg;
        flush_cnt_next   = flush_cnt_reg;
        if (freeze) begin
            if (state_reg == RUN) begin
                state_next    = MEM_WAIT;
                wait_cnt_next = WAIT_ONE;
            end else if (wait_cnt_reg != WAIT_MAX) begin
                wait_cnt_next = wait_cnt_reg + WAIT_ONE;
            end
            if (wait_cnt_next == WAIT_MAX) begin
                mem_timeout_next = 1'b1;
            end
        end else begin
            state_next    = RUN;
            wait_cnt_next = '0;
        end
        if (!pc_write && (stall_cnt_reg != CNT_MAX)) begin
            stall_cnt_next = stall_cnt_reg + 1'b1;
        end
        if (branch && (flush_cnt_reg != CNT_MAX)) begin
            flush_cnt_next = flush_cnt_reg + 1'b1;
        end
    end

    // State and counter registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg       <= RUN;
            wait_cnt_reg    <= '0;
            stall_cnt_reg   <= '0;
            flush_cnt_reg   <= '0;
            mem_timeout_reg <= 1'b0;
        end else begin
            state_reg       <= state_next;
            wait_cnt_reg    <= wait_cnt_next;
            stall_cnt_reg   <= stall_cnt_next;
            flush_cnt_reg   <= flush_cnt_next;
            mem_timeout_reg <= mem_timeout_next;
        end
    end

    assign bus.pc_write     = pc_write;
    assign bus.ifid_write   = ifid_write;
    assign bus.ifid_flush   = ifid_flush;
    assign bus.idex_write   = idex_write;
    assign bus.idex_flush   = idex_flush;
    assign bus.exmem_write  = exmem_write;
    assign bus.memwb_bubble = memwb_bubble;
    assign bus.stall_cnt    = stall_cnt_reg;
    assign bus.flush_cnt    = flush_cnt_reg;
    assign bus.mem_timeout  = mem_timeout_reg;
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl: each driven cycle pushes the
// expected controls/counters; they are popped and compared after the edge.
module tb_pipeline_hazard_ctrl;
    localparam int REG_W = 5;
    localparam int CNT_W = 4;
    localparam int TMO   = 4;
    localparam logic [CNT_W-1:0] CMAX = '1;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    pipeline_hazard_ctrl_if #(.REG_W(REG_W), .CNT_W(CNT_W)) bus ();

    pipeline_hazard_ctrl #(.REG_W(REG_W), .CNT_W(CNT_W), .MEM_TIMEOUT(TMO)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        string            tag;
        logic [6:0]       ctrl;
        logic [CNT_W-1:0] stall;
        logic [CNT_W-1:0] flush;
        logic             tmo;
    } exp_t;

    exp_t sb[$];
    int n_cmp = 0;
    int n_err = 0;

    // Reference state kept by the bench
    logic [CNT_W-1:0] m_stall = '0;
    logic [CNT_W-1:0] m_flush = '0;
    logic             m_tmo   = 1'b0;
    logic             m_wait  = 1'b0;
    int               m_wcnt  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // {pc_write, ifid_write, ifid_flush, idex_write, idex_flush, exmem_write, memwb_bubble}
    function automatic logic [6:0] model_ctrl(input logic rst_n, input logic [31:0] instr,
                                              input logic mr, input logic [4:0] rd,
                                              input logic br, input logic mem, input logic rdy);
        logic lu;
        lu = mr && (rd != 5'd0) && (rd == instr[19:15] || rd == instr[24:20]);
        if (!rst_n)          return 7'b0010101;
        if (mem && !rdy)     return 7'b0000001;
        if (br)              return 7'b1111110;
        if (lu)              return 7'b0001110;
        return 7'b1101010;
    endfunction

    function automatic logic [6:0] dut_ctrl();
        return {bus.pc_write, bus.ifid_write, bus.ifid_flush, bus.idex_write,
                bus.idex_flush, bus.exmem_write, bus.memwb_bubble};
    endfunction

    // One clock cycle: drive inputs after negedge, push expectation, compare after posedge
    task automatic cyc(input string tag, input logic rst_n, input logic [31:0] instr,
                       input logic mr, input logic [4:0] rd, input logic br,
                       input logic emr, input logic emw, input logic rdy);
        exp_t e;
        exp_t got_e;
        logic [6:0] ctrl_seen;
        logic frz;
        reset              = rst_n;
        bus.ifid_instr     = instr;
        bus.idex_memread   = mr;
        bus.idex_rd        = rd;
        bus.ex_branch_tkn  = br;
        bus.exmem_memread  = emr;
        bus.exmem_memwrite = emw;
        bus.dmem_ready     = rdy;

        e.tag  = tag;
        e.ctrl = model_ctrl(rst_n, instr, mr, rd, br, emr | emw, rdy);
        frz    = (emr | emw) & ~rdy;
        if (!rst_n) begin
            m_stall = '0; m_flush = '0; m_tmo = 1'b0; m_wait = 1'b0; m_wcnt = 0;
        end else begin
            if (!e.ctrl[6] && m_stall != CMAX) m_stall = m_stall + 1'b1;
            if (br && !frz && m_flush != CMAX) m_flush = m_flush + 1'b1;
            if (frz) begin
                m_wcnt = m_wait ? ((m_wcnt < TMO) ? m_wcnt + 1 : TMO) : 1;
                m_wait = 1'b1;
                if (m_wcnt == TMO) m_tmo = 1'b1;
            end else begin
                m_wait = 1'b0;
                m_wcnt = 0;
            end
        end
        e.stall = m_stall;
        e.flush = m_flush;
        e.tmo   = m_tmo;
        sb.push_back(e);

        #1;
        ctrl_seen = dut_ctrl();
        if (!rst_n) begin
            // Asynchronous reset clears counters without waiting for an edge
            check({tag, ".async_stall"}, 32'(bus.stall_cnt), 32'd0);
            check({tag, ".async_tmo"},   32'(bus.mem_timeout), 32'd0);
        end
        @(posedge clk);
        #1;
        got_e = sb.pop_front();
        check({got_e.tag, ".ctrl"},  32'(ctrl_seen),       32'(got_e.ctrl));
        check({got_e.tag, ".stall"}, 32'(bus.stall_cnt),   32'(got_e.stall));
        check({got_e.tag, ".flush"}, 32'(bus.flush_cnt),   32'(got_e.flush));
        check({got_e.tag, ".tmo"},   32'(bus.mem_timeout), 32'(got_e.tmo));
        $display("txn %-12s ctrl=%b stall=%0d flush=%0d tmo=%0b", got_e.tag, ctrl_seen,
                 bus.stall_cnt, bus.flush_cnt, bus.mem_timeout);
        @(negedge clk);
    endtask

    task automatic idle(input string tag, input logic rst_n);
        cyc(tag, rst_n, 32'h0000_0013, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        @(negedge clk);
        idle("reset0", 1'b0);
        idle("reset1", 1'b0);
        idle("idle", 1'b1);

        // Load-use on rs1, then normal
        cyc("lu_rs1", 1'b1, 32'(5) << 15, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, 1'b1);
        cyc("lu_after", 1'b1, 32'(5) << 15, 1'b0, 5'd5, 1'b0, 1'b0, 1'b0, 1'b1);
        // Load-use on rs2
        cyc("lu_rs2", 1'b1, 32'(7) << 20, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0, 1'b1);
        // x0 never creates a hazard
        idle("rst_a", 1'b0);
        cyc("lu_x0", 1'b1, 32'h0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        // Non-matching load destination
        cyc("lu_nomatch", 1'b1, 32'(3) << 15, 1'b1, 5'd4, 1'b0, 1'b0, 1'b0, 1'b1);

        // Taken branch with simultaneous load-use
        idle("rst_b", 1'b0);
        cyc("br_lu", 1'b1, 32'(9) << 15, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0, 1'b1);

        // Memory read wait: 3 frozen cycles then release
        idle("rst_c", 1'b0);
        for (int i = 0; i < 3; i++)
            cyc($sformatf("mrd_wait%0d", i), 1'b1, 32'h13, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        cyc("mrd_rel", 1'b1, 32'h13, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1);

        // Memory write wait of 6 cycles reaches the timeout; branch during freeze ignored
        idle("rst_d", 1'b0);
        for (int i = 0; i < 6; i++)
            cyc($sformatf("mwr_wait%0d", i), 1'b1, 32'h13, 1'b0, 5'd0, (i == 2), 1'b0, 1'b1, 1'b0);
        cyc("mwr_rel", 1'b1, 32'h13, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
        idle("tmo_sticky", 1'b1);

        // Reset pulse inside MEM_WAIT, then the access freezes again
        idle("rst_e", 1'b0);
        cyc("mw_first", 1'b1, 32'h13, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        cyc("mw_reset", 1'b0, 32'h13, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        cyc("mw_refrz", 1'b1, 32'h13, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        cyc("mw_rel", 1'b1, 32'h13, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1);

        // Counter saturation
        idle("rst_f", 1'b0);
        for (int i = 0; i < 18; i++)
            cyc($sformatf("sat_st%0d", i), 1'b1, 32'(2) << 15, 1'b1, 5'd2, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 18; i++)
            cyc($sformatf("sat_br%0d", i), 1'b1, 32'h13, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1);

        // Random mix against the model
        for (int i = 0; i < 40; i++) begin
            logic [4:0] r;
            r = 5'($urandom_range(0, 3));
            cyc($sformatf("rnd%0d", i), 1'b1,
                (32'($urandom_range(0, 3)) << 15) | (32'($urandom_range(0, 3)) << 20),
                1'($urandom_range(0, 1)), r, ($urandom_range(0, 3) == 0),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        if (sb.size() != 0) check("sb_empty", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Hard time limit so the run always terminates
    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "time limit");
    end
endmodule
